// File: rtl/xor_frame_checksum_if.sv
// Handshake bundle for xor_frame_checksum: word stream in, checksum result out.
// The master drives words and accepts results; the slave is the checksum block.
interface xor_frame_checksum_if #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_xor;
    logic             out_parity;
    logic [CW-1:0]    out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_xor, out_parity, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_xor, out_parity, out_count
    );
endinterface

// File: rtl/xor_frame_checksum.sv
// Frame checksum: XOR of up to FRAME_LEN words, closed early by in_last,
// then held on the output handshake with parity and word count.
module xor_frame_checksum #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    xor_frame_checksum_if.slave bus
);
    localparam int        CW       = $clog2(FRAME_LEN + 1);
    localparam logic [0:0] ACCUM   = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;
    localparam logic      ODD_BIT  = (ODD != 0);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_next;
    logic             accept;
    logic             close;
    logic             release_result;

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);

    assign accept         = bus.in_valid & bus.in_ready;
    assign acc_next       = acc ^ bus.in_data;
    assign cnt_next       = cnt + CW'(1);
    // The FRAME_LEN-th word closes the frame whether or not in_last is also set.
    assign close          = accept & (bus.in_last | (cnt == LAST_IDX));
    assign release_result = bus.out_valid & bus.out_ready;

    assign bus.out_parity = (^bus.out_xor) ^ ODD_BIT;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACCUM;
            acc           <= '0;
            cnt           <= '0;
            bus.out_xor   <= '0;
            bus.out_count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                    end
                    if (close) begin
                        bus.out_xor   <= acc_next;
                        bus.out_count <= cnt_next;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (release_result) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
